// File: rtl/uart_tx_param.sv
// uart_tx_param: buffered UART transmitter, start + DATA_BITS (LSB first) + optional parity + STOP_BITS.
// Latency: start bit drives tx 1 clk after the accepting write edge when idle; back-to-back frames have no gap.
// Backpressure: tx_full raised at FIFO_DEPTH words; a write while full without a same-cycle pop is dropped and flagged on wr_overflow.
//
// Optional feature macro: UART_TX_PARITY_EN (adds a parity bit after the data bits, polarity from PARITY_ODD).
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   wr_uart/data_in per-cycle write strobe and word
//   tx              registered serial line, idle high
//   tx_full/tx_empty/fifo_count  FIFO occupancy
//   tx_busy         high while a frame is on the line
//   wr_overflow     one-cycle pulse for each dropped write
module uart_tx_param #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_uart,
  input  logic [DATA_BITS-1:0]          data_in,
  output logic                          tx,
  output logic                          tx_full,
  output logic                          tx_empty,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          wr_overflow
);

  localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  // Elaboration-time guard against unsupported configurations.
  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
    $error("uart_tx_param: illegal parameter set");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CNTW-1:0]      count_q;
  logic                 pop;
  logic                 push;
  logic [DATA_BITS-1:0] head;

  assign tx_full    = (count_q == CNTW'(FIFO_DEPTH));
  assign tx_empty   = (count_q == '0);
  assign fifo_count = count_q;
  assign head       = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write then.
  assign push = wr_uart && (!tx_full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      wr_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      wr_overflow <= wr_uart && tx_full && !pop;
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t               state, state_n;
  logic [CW-1:0]        baud_cnt, baud_n;
  logic [3:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic                 tx_q, tx_n;
  logic                 baud_last;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_n;
`endif

  assign baud_last = (baud_cnt == CW'(DIV - 1));
  assign tx        = tx_q;
  assign tx_busy   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= sh_n;
      tx_q     <= tx_n;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_n;
`endif
    end
  end

  // tx is registered: tx_n is the level of the bit the FSM enters on this edge.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    tx_n    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!tx_empty) pop = 1'b1;
      end
      START: begin
        baud_n = baud_cnt + 1'b1;
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        baud_n = baud_cnt + 1'b1;
        if (baud_last) begin
          baud_n = '0;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par_q;
`else
            state_n = STOP;
            bit_n   = '0;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n = bit_cnt + 1'b1;
            sh_n  = {1'b0, shreg[DATA_BITS-1:1]};
            tx_n  = shreg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        baud_n = baud_cnt + 1'b1;
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_n   = 1'b1;
        baud_n = baud_cnt + 1'b1;
        if (baud_last) begin
          baud_n = '0;
          if (bit_cnt == 4'(STOP_BITS - 1)) begin
            // Chain straight into the next frame when data is waiting.
            if (!tx_empty) pop = 1'b1;
            else           state_n = IDLE;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    // Frame load: shared by IDLE and end-of-STOP.
    if (pop) begin
      sh_n    = head;
      baud_n  = '0;
      state_n = START;
      tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
      // Parity captured at load since the shift register is consumed in DATA.
      par_n   = (^head) ^ (PARITY_ODD != 0);
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

  localparam int CLK_HZ     = 100_000_000;
  localparam int BAUD       = 10_000_000;
  localparam int DIV        = 10;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB8 = 1 + 8 + P + 1;
  localparam int FL8 = NB8 * DIV;
  localparam int FL5 = (1 + 5 + P + 2) * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr8, wr5;
  logic [7:0] data8;
  logic [4:0] data5;
  logic       tx8, full8, empty8, busy8, ovf8;
  logic       tx5, full5, empty5, busy5, ovf5;
  logic [4:0] count8, count5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .STOP_BITS(1),
                  .FIFO_DEPTH(16), .PARITY_ODD(PARITY_ODD)) u_dut (
    .clk(clk), .reset(reset), .wr_uart(wr8), .data_in(data8), .tx(tx8),
    .tx_full(full8), .tx_empty(empty8), .tx_busy(busy8), .fifo_count(count8),
    .wr_overflow(ovf8));

  uart_tx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(5), .STOP_BITS(2),
                  .FIFO_DEPTH(16), .PARITY_ODD(PARITY_ODD)) u_dut5 (
    .clk(clk), .reset(reset), .wr_uart(wr5), .data_in(data5), .tx(tx5),
    .tx_full(full5), .tx_empty(empty5), .tx_busy(busy5), .fifo_count(count5),
    .wr_overflow(ovf5));

  // Reference: line level for frame bit idx of word w; indices past the frame read as idle/stop (1).
  function automatic logic frame_bit(input logic [8:0] w, input int db, input int idx);
    int ones;
    ones = 0;
    for (int i = 0; i < db; i++) ones += int'(w[i]);
    if (idx == 0) return 1'b0;
    if (idx <= db) return w[idx-1];
    if (P == 1 && idx == db + 1) return ((ones % 2) == 1) ^ (PARITY_ODD != 0);
    return 1'b1;
  endfunction

  task automatic test_reset();
    int lows;
    reset = 1'b1;
    #10;
    reset = 1'b0;
    #1;
    n_cmp++; if (tx8 !== 1'b1) begin n_bad++; $display("FAIL reset_tx got %b want 1", tx8); end
    n_cmp++; if (empty8 !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", empty8); end
    n_cmp++; if (count8 !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count8); end
    n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy8); end
    n_cmp++; if (full8 !== 1'b0 || ovf8 !== 1'b0) begin n_bad++; $display("FAIL reset_full_ovf got %b%b want 00", full8, ovf8); end
    n_cmp++; if (tx5 !== 1'b1 || busy5 !== 1'b0) begin n_bad++; $display("FAIL reset_dut5 got tx=%b busy=%b want tx=1 busy=0", tx5, busy5); end
    lows = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx8 !== 1'b1) lows++;
    end
    n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL idle_line got %0d low cycles want 0", lows); end
  endtask

  task automatic test_single(input logic [7:0] w);
    logic [2047:0] obs, expv;
    int busy_n, first;
    obs = '0; expv = '0; busy_n = 0;
    @(negedge clk); wr8 = 1'b1; data8 = w;
    @(negedge clk); wr8 = 1'b0;
    n_cmp++; if (count8 !== 5'd1 || tx8 !== 1'b1 || busy8 !== 1'b0) begin
      n_bad++; $display("FAIL single_accept got cnt=%0d tx=%b busy=%b want cnt=1 tx=1 busy=0", count8, tx8, busy8);
    end
    for (int c = 0; c < FL8; c++) begin
      @(negedge clk);
      obs[c]  = tx8;
      expv[c] = frame_bit({1'b0, w}, 8, c / DIV);
      if (busy8 === 1'b1) busy_n++;
    end
    n_cmp++; if (obs !== expv) begin
      first = 0;
      while (first < FL8 && obs[first] === expv[first]) first++;
      n_bad++; $display("FAIL single_line word %h: clk %0d got %b want %b", w, first, obs[first], expv[first]);
    end
    n_cmp++; if (busy_n != FL8) begin n_bad++; $display("FAIL single_busy got %0d clks want %0d", busy_n, FL8); end
    @(negedge clk);
    n_cmp++; if (tx8 !== 1'b1 || busy8 !== 1'b0 || empty8 !== 1'b1) begin
      n_bad++; $display("FAIL single_after got tx=%b busy=%b empty=%b want 1 0 1", tx8, busy8, empty8);
    end
  endtask

  task automatic test_burst();
    logic [2047:0] obs, expv;
    int ovf_n, exp_cnt, first, total;
    obs = '0; expv = '0; ovf_n = 0;
    total = 17 * FL8;
    @(negedge clk);
    for (int n = 0; n <= 2 + total; n++) begin
      if (n > 0) begin
        if (n >= 2 && n < 2 + total) obs[n-2] = tx8;
        if (ovf8 === 1'b1) ovf_n++;
        if (n <= 18) begin
          exp_cnt = (n == 1) ? 1 : ((n - 1 > 16) ? 16 : n - 1);
          n_cmp++; if (count8 !== 5'(exp_cnt)) begin
            n_bad++; $display("FAIL burst_count after write %0d got %0d want %0d", n, count8, exp_cnt);
          end
        end
        if (n == 17) begin
          n_cmp++; if (full8 !== 1'b1) begin n_bad++; $display("FAIL burst_full got %b want 1", full8); end
        end
        if (n == 2 + total) begin
          n_cmp++; if (tx8 !== 1'b1 || busy8 !== 1'b0 || empty8 !== 1'b1) begin
            n_bad++; $display("FAIL burst_after got tx=%b busy=%b empty=%b want 1 0 1", tx8, busy8, empty8);
          end
        end
      end
      if (n < 18) begin wr8 = 1'b1; data8 = 8'(n); end
      else wr8 = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < total; i++) expv[i] = frame_bit(9'(i / FL8), 8, (i % FL8) / DIV);
    n_cmp++; if (obs !== expv) begin
      first = 0;
      while (first < total && obs[first] === expv[first]) first++;
      n_bad++; $display("FAIL burst_line clk %0d (frame %0d) got %b want %b", first, first / FL8, obs[first], expv[first]);
    end
    n_cmp++; if (ovf_n != 1) begin n_bad++; $display("FAIL burst_overflow got %0d pulses want 1", ovf_n); end
  endtask

  task automatic test_reset_mid(input logic [7:0] w);
    int lows;
    logic lvl;
    @(negedge clk); wr8 = 1'b1; data8 = w;
    @(negedge clk); data8 = w + 8'd1;
    @(negedge clk); data8 = w + 8'd2;
    @(negedge clk); wr8 = 1'b0;
    repeat (47 - 3) @(negedge clk);
    lvl = frame_bit({1'b0, w}, 8, 45 / DIV);
    n_cmp++; if (tx8 !== lvl || count8 !== 5'd2) begin
      n_bad++; $display("FAIL midreset_before word %h got tx=%b cnt=%0d want tx=%b cnt=2", w, tx8, count8, lvl);
    end
    reset = 1'b1;
    #1;
    n_cmp++; if (tx8 !== 1'b1 || count8 !== 5'd0 || busy8 !== 1'b0 || empty8 !== 1'b1) begin
      n_bad++; $display("FAIL midreset_async got tx=%b cnt=%0d busy=%b empty=%b want 1 0 0 1", tx8, count8, busy8, empty8);
    end
    @(negedge clk); reset = 1'b0;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx8 !== 1'b1 || busy8 !== 1'b0) lows++;
    end
    n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL midreset_residual got %0d active cycles want 0", lows); end
  endtask

  task automatic test_five_two(input logic [4:0] w);
    logic [2047:0] obs, expv;
    int busy_n, first;
    obs = '0; expv = '0; busy_n = 0;
    @(negedge clk); wr5 = 1'b1; data5 = w;
    @(negedge clk); wr5 = 1'b0;
    if (busy5 === 1'b1) busy_n++;
    for (int c = 0; c < FL5 + 10; c++) begin
      @(negedge clk);
      obs[c]  = tx5;
      expv[c] = frame_bit({4'b0, w}, 5, c / DIV);
      if (busy5 === 1'b1) busy_n++;
    end
    n_cmp++; if (obs !== expv) begin
      first = 0;
      while (first < FL5 + 10 && obs[first] === expv[first]) first++;
      n_bad++; $display("FAIL five_line word %h: clk %0d got %b want %b", w, first, obs[first], expv[first]);
    end
    n_cmp++; if (busy_n != FL5) begin n_bad++; $display("FAIL five_busy got %0d clks want %0d", busy_n, FL5); end
  endtask

  task automatic test_random();
    logic [7:0] words [16];
    int nw, t;
    for (int r = 0; r < 3; r++) begin
      nw = $urandom_range(1, 16);
      for (int k = 0; k < 16; k++) words[k] = 8'($urandom);
      @(negedge clk);
      fork
        begin
          for (int k = 0; k < nw; k++) begin
            wr8 = 1'b1; data8 = words[k];
            @(negedge clk); wr8 = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
          end
        end
        begin
          logic [15:0] got, want;
          int cyc, wt;
          for (int f = 0; f < nw; f++) begin
            wt = 0;
            while (tx8 !== 1'b0 && wt < 3000) begin @(negedge clk); wt++; end
            if (wt >= 3000) begin
              n_cmp++; n_bad++;
              $display("FAIL random_start round %0d frame %0d got no start bit want start within 3000 clks", r, f);
              break;
            end
            got = '0; want = '0; cyc = 0;
            for (int b = 0; b < NB8; b++) begin
              while (cyc < b * DIV + DIV / 2) begin @(negedge clk); cyc++; end
              got[b]  = tx8;
              want[b] = frame_bit({1'b0, words[f]}, 8, b);
            end
            n_cmp++; if (got !== want) begin
              n_bad++; $display("FAIL random_frame round %0d frame %0d got %b want %b", r, f, got, want);
            end
          end
        end
      join
      t = 0;
      while (busy8 !== 1'b0 && t < 200) begin @(negedge clk); t++; end
      n_cmp++; if (busy8 !== 1'b0 || empty8 !== 1'b1) begin
        n_bad++; $display("FAIL random_drain round %0d got busy=%b empty=%b want 0 1", r, busy8, empty8);
      end
    end
  endtask

  initial begin
    wr8 = 1'b0; data8 = '0; wr5 = 1'b0; data5 = '0;
    test_reset();
    test_single(8'h54);
    test_single(8'($urandom));
    test_burst();
    test_reset_mid(8'hDF);
    test_reset_mid(8'h00);
    test_five_two(5'h1F);
    test_five_two(5'($urandom));
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
